current_loop_controller: RTL and testbench

Digital control loop for the current source controller. It consumes the divided loop clock from the divide-by-8 stage (SLOW_CLK) and runs on the fast system clock. On every rising edge of SLOW_CLK it steps a DAC code up or down according to the current comparator, which gives a low-rate update. It flags lock once the code dithers around the target and flags saturation at the code limits.

---
 rtl/csc_pkg.sv | 20 ++
 rtl/sync_edge_detect.sv | 29 ++
 rtl/current_loop_controller.sv | 143 ++++++++++++++
 tb/tb_current_loop_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// rtl/csc_pkg.sv - shared types and constants for the current loop controller
// Loop state encoding and direction-history counter width.
package csc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int REVCNT_W = 4;
  localparam logic [REVCNT_W-1:0] CNT_MAX = '1;
  localparam logic [REVCNT_W-1:0] CNT_ONE = {{(REVCNT_W-1){1'b0}}, 1'b1};

  // Saturating increment for the reversal / run counters.
  function automatic logic [REVCNT_W-1:0] cnt_inc(input logic [REVCNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with rising-edge pulse
// The edge pulse is high for one clock after the synchronized input goes high.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic s1_q, s2_q, prev_q;

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/current_loop_controller.sv
// rtl/current_loop_controller.sv - DAC code stepping loop with lock and saturation flags
// Steps the code once per SLOW_CLK rising edge toward the comparator target and
// tracks direction reversals to decide when the loop is dithering (locked).
module current_loop_controller
  import csc_pkg::*;
#(
  parameter int CODE_W     = 8,
  parameter int CODE_INIT  = 128,
  parameter int LOCK_REV   = 4,
  parameter int UNLOCK_RUN = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              SLOW_CLK,
  input  logic              COMP_IN,
  output logic [CODE_W-1:0] CODE,
  output logic              LOCK,
  output logic              SAT,
  output logic              UPDATE
);

  localparam logic [CODE_W-1:0]   CODE_INIT_C  = CODE_INIT[CODE_W-1:0];
  localparam logic [CODE_W-1:0]   CODE_MAX     = '1;
  localparam logic [CODE_W-1:0]   CODE_ONE     = {{(CODE_W-1){1'b0}}, 1'b1};
  localparam logic [REVCNT_W-1:0] LOCK_REV_C   = LOCK_REV[REVCNT_W-1:0];
  localparam logic [REVCNT_W-1:0] UNLOCK_RUN_C = UNLOCK_RUN[REVCNT_W-1:0];

  logic tick, dir, comp_rise_unused;

  sync_edge_detect u_slow_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .async_i(SLOW_CLK),
    .sync_o (),
    .rise_o (tick)
  );

  sync_edge_detect u_comp_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .async_i(COMP_IN),
    .sync_o (dir),
    .rise_o (comp_rise_unused)
  );

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                lock_q, lock_d, sat_q, sat_d, update_q, update_d;
  logic                dir_valid_q, dir_valid_d, last_dir_q, last_dir_d;
  logic [REVCNT_W-1:0] rev_q, rev_d, run_q, run_d;

  // Next-state logic: stepping, direction history and lock decisions.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    lock_d      = lock_q;
    update_d    = 1'b0;
    dir_valid_d = dir_valid_q;
    last_dir_d  = last_dir_q;
    rev_d       = rev_q;
    run_d       = run_q;
    case (state_q)
      ST_IDLE: begin
        code_d      = CODE_INIT_C;
        lock_d      = 1'b0;
        dir_valid_d = 1'b0;
        last_dir_d  = 1'b0;
        rev_d       = '0;
        run_d       = '0;
        if (EN) state_d = ST_TRACK;
      end
      ST_TRACK, ST_LOCKED: begin
        if (!EN) begin
          state_d     = ST_IDLE;
          code_d      = CODE_INIT_C;
          lock_d      = 1'b0;
          dir_valid_d = 1'b0;
          rev_d       = '0;
          run_d       = '0;
        end else if (tick) begin
          update_d = 1'b1;
          if (dir) code_d = (code_q == CODE_MAX) ? code_q : code_q + CODE_ONE;
          else     code_d = (code_q == '0) ? code_q : code_q - CODE_ONE;
          last_dir_d  = dir;
          dir_valid_d = 1'b1;
          // The first tick after leaving IDLE only seeds the direction history.
          if (dir_valid_q) begin
            if (dir != last_dir_q) begin
              rev_d = cnt_inc(rev_q);
              run_d = '0;
            end else begin
              run_d = cnt_inc(run_q);
              rev_d = '0;
            end
          end
          if (state_q == ST_TRACK && rev_d == LOCK_REV_C) begin
            state_d = ST_LOCKED;
            lock_d  = 1'b1;
            run_d   = '0;
          end else if (state_q == ST_LOCKED && run_d == UNLOCK_RUN_C) begin
            state_d = ST_TRACK;
            lock_d  = 1'b0;
            rev_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sat_d = (code_d == '0) || (code_d == CODE_MAX);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      code_q      <= CODE_INIT_C;
      lock_q      <= 1'b0;
      sat_q       <= 1'b0;
      update_q    <= 1'b0;
      dir_valid_q <= 1'b0;
      last_dir_q  <= 1'b0;
      rev_q       <= '0;
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      lock_q      <= lock_d;
      sat_q       <= sat_d;
      update_q    <= update_d;
      dir_valid_q <= dir_valid_d;
      last_dir_q  <= last_dir_d;
      rev_q       <= rev_d;
      run_q       <= run_d;
    end
  end

  assign CODE   = code_q;
  assign LOCK   = lock_q;
  assign SAT    = sat_q;
  assign UPDATE = update_q;

endmodule

// File: tb/tb_current_loop_controller.sv
// tb/tb_current_loop_controller.sv - self-checking bench for current_loop_controller
module tb_current_loop_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slow_clk = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, comp_a = 1'b0, comp_b = 1'b0;
  logic [7:0] code_a;
  logic [3:0] code_b;
  logic lock_a, sat_a, upd_a, lock_b, sat_b, upd_b;

  int n_checks = 0;
  int n_pass = 0;
  int upd_cnt_a = 0;
  int upd_cnt_b = 0;

  typedef struct {
    int code;
    bit lock;
    bit sat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  current_loop_controller #(.CODE_W(8), .CODE_INIT(128), .LOCK_REV(4), .UNLOCK_RUN(3)) dut_a (
    .CLK(clk), .RST_N(rst_n), .EN(en_a), .SLOW_CLK(slow_clk), .COMP_IN(comp_a),
    .CODE(code_a), .LOCK(lock_a), .SAT(sat_a), .UPDATE(upd_a)
  );

  current_loop_controller #(.CODE_W(4), .CODE_INIT(14), .LOCK_REV(4), .UNLOCK_RUN(3)) dut_b (
    .CLK(clk), .RST_N(rst_n), .EN(en_b), .SLOW_CLK(slow_clk), .COMP_IN(comp_b),
    .CODE(code_b), .LOCK(lock_b), .SAT(sat_b), .UPDATE(upd_b)
  );

  always @(posedge clk) begin
    if (upd_a === 1'b1) upd_cnt_a <= upd_cnt_a + 1;
    if (upd_b === 1'b1) upd_cnt_b <= upd_cnt_b + 1;
  end

  function automatic int obs_code(bit w);
    return w ? int'(code_b) : int'(code_a);
  endfunction
  function automatic bit obs_lock(bit w);
    return w ? lock_b : lock_a;
  endfunction
  function automatic bit obs_sat(bit w);
    return w ? sat_b : sat_a;
  endfunction
  function automatic bit obs_upd(bit w);
    return w ? upd_b : upd_a;
  endfunction
  function automatic int obs_cnt(bit w);
    return w ? upd_cnt_b : upd_cnt_a;
  endfunction

  // One SLOW_CLK period with the given comparator level; expected result goes via the scoreboard.
  task automatic step(input bit w, input bit comp, input int ec, input bit el, input bit es);
    exp_t e;
    bit seen;
    int base;
    @(negedge clk);
    if (w) comp_b = comp; else comp_a = comp;
    repeat (3) @(negedge clk);
    base = obs_cnt(w);
    e.code = ec; e.lock = el; e.sat = es;
    sb_q.push_back(e);
    slow_clk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (obs_upd(w) === 1'b1) seen = 1'b1;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (!seen) $display("FAIL step_update: no UPDATE within 8 cycles (expected code %0d)", e.code);
    else n_pass++;
    n_checks++;
    if (obs_code(w) !== e.code) $display("FAIL step_code: got %0d expected %0d", obs_code(w), e.code);
    else n_pass++;
    n_checks++;
    if (obs_lock(w) !== e.lock) $display("FAIL step_lock: got %0b expected %0b (code %0d)", obs_lock(w), e.lock, e.code);
    else n_pass++;
    n_checks++;
    if (obs_sat(w) !== e.sat) $display("FAIL step_sat: got %0b expected %0b (code %0d)", obs_sat(w), e.sat, e.code);
    else n_pass++;
    repeat (4) @(negedge clk);
    slow_clk = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (obs_cnt(w) - base !== 1) $display("FAIL step_pulses: got %0d UPDATE cycles expected 1", obs_cnt(w) - base);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      slow_clk = ~slow_clk;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (6) @(negedge clk);
      slow_clk = ~slow_clk;
    end
    repeat (6) @(negedge clk);
    slow_clk = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (code_a !== 8'd128) $display("FAIL reset_code: got %0d expected 128", code_a); else n_pass++;
    n_checks++;
    if (lock_a !== 1'b0 || sat_a !== 1'b0) $display("FAIL reset_flags: lock %0b sat %0b expected 0 0", lock_a, sat_a); else n_pass++;
    n_checks++;
    if (upd_cnt_a !== 0 || upd_a !== 1'b0) $display("FAIL reset_update: got %0d pulses expected 0", upd_cnt_a); else n_pass++;
    n_checks++;
    if (code_b !== 4'd14 || sat_b !== 1'b0) $display("FAIL reset_small: code %0d sat %0b expected 14 0", code_b, sat_b); else n_pass++;
  endtask

  task automatic test_tick_latency();
    bit [4:1] seen_upd;
    int code_at_e2;
    en_a = 1'b1;
    comp_a = 1'b1;
    repeat (6) @(negedge clk);
    slow_clk = 1'b1;
    code_at_e2 = -1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      seen_upd[k] = upd_a;
      if (k == 3) code_at_e2 = int'(code_a);
    end
    n_checks++;
    if (seen_upd !== 4'b0100) $display("FAIL tick_latency: UPDATE pattern e0..e3 got %b expected 0100", {seen_upd[1], seen_upd[2], seen_upd[3], seen_upd[4]});
    else n_pass++;
    n_checks++;
    if (code_at_e2 !== 129) $display("FAIL tick_code: got %0d expected 129", code_at_e2); else n_pass++;
    repeat (4) @(negedge clk);
    slow_clk = 1'b0;
    repeat (6) @(negedge clk);
    for (int c = 130; c <= 138; c++) step(1'b0, 1'b1, c, 1'b0, 1'b0);
    n_checks++;
    if (upd_cnt_a !== 10) $display("FAIL ten_ticks: got %0d pulses expected 10", upd_cnt_a); else n_pass++;
  endtask

  task automatic test_lock();
    @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (code_a !== 8'd128) $display("FAIL reenable_code: got %0d expected 128", code_a); else n_pass++;
    en_a = 1'b1;
    step(1'b0, 1'b1, 129, 1'b0, 1'b0);
    step(1'b0, 1'b0, 128, 1'b0, 1'b0);
    step(1'b0, 1'b1, 129, 1'b0, 1'b0);
    step(1'b0, 1'b0, 128, 1'b0, 1'b0);
    step(1'b0, 1'b1, 129, 1'b1, 1'b0);
  endtask

  task automatic test_unlock();
    step(1'b0, 1'b0, 128, 1'b1, 1'b0);
    step(1'b0, 1'b1, 129, 1'b1, 1'b0);
    step(1'b0, 1'b1, 130, 1'b1, 1'b0);
    step(1'b0, 1'b1, 131, 1'b1, 1'b0);
    step(1'b0, 1'b1, 132, 1'b0, 1'b0);
  endtask

  task automatic test_enable_drop();
    int base;
    step(1'b0, 1'b0, 131, 1'b0, 1'b0);
    step(1'b0, 1'b1, 132, 1'b0, 1'b0);
    step(1'b0, 1'b0, 131, 1'b0, 1'b0);
    step(1'b0, 1'b1, 132, 1'b1, 1'b0);
    step(1'b0, 1'b0, 131, 1'b1, 1'b0);
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (code_a !== 8'd128 || lock_a !== 1'b0 || upd_a !== 1'b0)
      $display("FAIL en_drop: code %0d lock %0b update %0b expected 128 0 0", code_a, lock_a, upd_a);
    else n_pass++;
    base = upd_cnt_a;
    slow_clk = 1'b1;
    repeat (8) @(negedge clk);
    slow_clk = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (upd_cnt_a !== base || code_a !== 8'd128)
      $display("FAIL idle_ignores_tick: pulses %0d code %0d expected 0 128", upd_cnt_a - base, code_a);
    else n_pass++;
    en_a = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (upd_cnt_a !== base) $display("FAIL stale_tick: got %0d pulses expected 0", upd_cnt_a - base); else n_pass++;
    step(1'b0, 1'b1, 129, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    en_a = 1'b0;
    en_b = 1'b1;
    repeat (4) @(negedge clk);
    step(1'b1, 1'b1, 15, 1'b0, 1'b1);
    step(1'b1, 1'b1, 15, 1'b0, 1'b1);
    step(1'b1, 1'b1, 15, 1'b0, 1'b1);
    step(1'b1, 1'b0, 14, 1'b0, 1'b0);
    n_checks++;
    if (upd_cnt_b !== 4) $display("FAIL sat_pulses: got %0d expected 4", upd_cnt_b); else n_pass++;
  endtask

  task automatic test_async_reset();
    int base;
    en_a = 1'b1;
    repeat (4) @(negedge clk);
    step(1'b0, 1'b1, 129, 1'b0, 1'b0);
    @(negedge clk);
    slow_clk = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (code_a !== 8'd128 || lock_a !== 1'b0 || sat_a !== 1'b0 || upd_a !== 1'b0)
      $display("FAIL async_reset: code %0d lock %0b sat %0b update %0b expected 128 0 0 0", code_a, lock_a, sat_a, upd_a);
    else n_pass++;
    repeat (3) @(negedge clk);
    slow_clk = 1'b0;
    base = upd_cnt_a;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (upd_cnt_a !== base || code_a !== 8'd128)
      $display("FAIL after_reset: pulses %0d code %0d expected 0 128", upd_cnt_a - base, code_a);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tick_latency();
    test_lock();
    test_unlock();
    test_enable_drop();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
